// File: rtl/alu_muldiv.sv
// Single-issue integer ALU with iterative multiply (shift-add) and restoring divide.
// One request in flight; the result is held in DONE until the consumer takes it.
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      alu_op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] rd_data_o
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              accept, is_long, last_iter;
  logic [CW-1:0]     cnt;
  logic [4:0]        op_q;
  logic [XLEN-1:0]   b_q, rs1_q, rd_q;
  logic              neg_q, div0_q;
  logic [XLEN:0]     work_hi, hi_nxt, mul_sum, div_trial;
  logic [XLEN-1:0]   work_lo, lo_nxt;
  logic              div_ge;
  logic              a_signed, b_signed, a_neg, b_neg, neg_init;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem, long_res;

  function automatic logic [XLEN-1:0] basic_op(input logic [4:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic [SHW-1:0]         sh;
    sa = a;
    sh = b[SHW-1:0];
    case (op)
      5'd0:    basic_op = a + b;
      5'd1:    basic_op = a - b;
      5'd2:    basic_op = a << sh;
      5'd3:    basic_op = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd4:    basic_op = {{(XLEN-1){1'b0}}, (a < b)};
      5'd5:    basic_op = a ^ b;
      5'd6:    basic_op = a >> sh;
      5'd7:    basic_op = sa >>> sh;
      5'd8:    basic_op = a | b;
      5'd9:    basic_op = a & b;
      default: basic_op = '0;
    endcase
  endfunction

  assign is_long   = (alu_op_i >= 5'd10) && (alu_op_i <= 5'd17);
  assign accept    = in_valid_i && in_ready_o;
  assign last_iter = (cnt == CW'(XLEN - 1));

  // Signed ops run on magnitudes; the sign is reapplied when the last bit lands.
  always_comb begin
    a_signed = (alu_op_i == 5'd11) || (alu_op_i == 5'd12) ||
               (alu_op_i == 5'd14) || (alu_op_i == 5'd16);
    b_signed = (alu_op_i == 5'd11) || (alu_op_i == 5'd14) || (alu_op_i == 5'd16);
    a_neg    = a_signed && rs1_data_i[XLEN-1];
    b_neg    = b_signed && rs2_data_i[XLEN-1];
    a_mag    = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag    = b_neg ? -rs2_data_i : rs2_data_i;
    neg_init = (alu_op_i == 5'd16) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    mul_sum   = work_hi + {1'b0, ({XLEN{work_lo[0]}} & b_q)};
    div_trial = {work_hi[XLEN-1:0], work_lo[XLEN-1]};
    div_ge    = (div_trial >= {1'b0, b_q});
    if (op_q >= 5'd14) begin
      hi_nxt = div_ge ? (div_trial - {1'b0, b_q}) : div_trial;
      lo_nxt = {work_lo[XLEN-2:0], div_ge};
    end else begin
      hi_nxt = {1'b0, mul_sum[XLEN:1]};
      lo_nxt = {mul_sum[0], work_lo[XLEN-1:1]};
    end
  end

  // Result is formed from the final iteration's values so DONE follows the last step directly.
  always_comb begin
    prod     = {hi_nxt[XLEN-1:0], lo_nxt};
    prod_fix = neg_q ? -prod : prod;
    quo      = neg_q ? -lo_nxt : lo_nxt;
    rem      = neg_q ? -hi_nxt[XLEN-1:0] : hi_nxt[XLEN-1:0];
    case (op_q)
      5'd10:                long_res = prod_fix[XLEN-1:0];
      5'd11, 5'd12, 5'd13:  long_res = prod_fix[2*XLEN-1:XLEN];
      5'd14, 5'd15:         long_res = div0_q ? '1 : quo;
      default:              long_res = div0_q ? rs1_q : rem;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_long ? BUSY : DONE;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state == IDLE) && !rst_i && !flush_i;
    out_valid_o = (state == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
      cnt  <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (accept) begin
      cnt     <= '0;
      op_q    <= alu_op_i;
      b_q     <= b_mag;
      work_hi <= '0;
      work_lo <= a_mag;
      neg_q   <= neg_init;
      div0_q  <= (rs2_data_i == '0);
      rs1_q   <= rs1_data_i;
      if (!is_long) rd_q <= basic_op(alu_op_i, rs1_data_i, rs2_data_i);
    end else if (state == BUSY) begin
      work_hi <= hi_nxt;
      work_lo <= lo_nxt;
      cnt     <= cnt + CW'(1);
      if (last_iter) rd_q <= long_res;
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized and directed bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [4:0]  op;
  logic [31:0] rs1, rs2, rd;
  int          total = 0;
  int          bad = 0;
  time         acc_t;

  typedef struct {
    logic [4:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    int          st;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  alu_muldiv dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .alu_op_i    (op),
    .rs1_data_i  (rs1),
    .rs2_data_i  (rs2),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .rd_data_o   (rd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] up;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (ia < ib) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'($signed(a) >>> b[4:0]);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      5'd11: begin p = sa * sb; return p[63:32]; end
      5'd12: begin p = sa * ub; return p[63:32]; end
      5'd13: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      5'd14: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      5'd15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      5'd17: return (b == 32'd0) ? a : a % b;
      default: begin
        if (ua == ub) return 32'd0;
        return 32'd0;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called right after a falling edge; returns right after the accepting rising edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    chk("rdy", {31'd0, in_ready}, 32'd1);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk);
    acc_t = $time;
    #1;
    in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 5'($urandom);
  endtask

  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input logic [31:0] lit, input bit use_lit);
    logic [31:0] exp;
    int          n, lat_exp;
    bit          seen;
    exp     = ref_model(o, a, b);
    lat_exp = (o >= 5'd10 && o <= 5'd17) ? 33 : 1;
    issue(o, a, b);
    out_ready = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      in_valid = 1'($urandom_range(0, 1)); rs1 = $urandom; rs2 = $urandom; op = 5'($urandom);
      @(negedge clk);
      n++;
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    chk($sformatf("lat op%0d", o), 32'(n), 32'(lat_exp));
    chk($sformatf("res op%0d a=%h b=%h", o, a, b), rd, exp);
    if (use_lit) chk($sformatf("lit op%0d", o), rd, lit);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; rs1 = $urandom; rs2 = $urandom; op = 5'($urandom);
      @(negedge clk);
      chk("hold_v", {31'd0, out_valid}, 32'd1);
      chk("hold_d", rd, exp);
      chk("hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("once", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic abort_div(input bit use_rst);
    int vcnt;
    issue(5'd14, 32'd1000, 32'd7);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    in_valid = 1'b1; op = 5'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("abort_v", {31'd0, out_valid}, 32'd0);
    if (use_rst) chk("abort_rd", rd, 32'd0);
    #1;
    chk("abort_rdy", {31'd0, in_ready}, 32'd1);
    vcnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("stale", 32'(vcnt), 32'd0);
    out_ready = 1'b0;
    run_op(5'd0, 32'd2, 32'd3, 0, 32'd5, 1'b1);
  endtask

  initial begin
    time t1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 5'd0; rs1 = 32'd0; rs2 = 32'd0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_v", {31'd0, out_valid}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    vecs = '{
      '{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0},
      '{5'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0},
      '{5'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0},
      '{5'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0},
      '{5'd2,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 0},
      '{5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0},
      '{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0},
      '{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0},
      '{5'd10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 0},
      '{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5},
      '{5'd16, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0},
      '{5'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0},
      '{5'd15, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0},
      '{5'd17, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0},
      '{5'd22, 32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 5}
    };
    foreach (vecs[i]) run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].st, vecs[i].e, 1'b1);

    run_op(5'd5, 32'h1234_5678, 32'h0F0F_0F0F, 0, 32'd0, 1'b0);
    t1 = acc_t;
    run_op(5'd8, 32'h1234_5678, 32'h0F0F_0F0F, 0, 32'd0, 1'b0);
    chk("thruput", 32'((acc_t - t1) / 10), 32'd2);

    abort_div(1'b0);
    abort_div(1'b1);

    for (int k = 0; k < 300; k++) begin
      logic [4:0]  ro;
      logic [31:0] ra, rb;
      ro = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, $urandom_range(0, 2), 32'd0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (power of 2, >=8).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), meaning shift-amount width taken from rs2_data_i[SHW-1:0].
REQ-003 SHALL have port clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid_i  input  1  request valid.
REQ-006 SHALL have port in_ready_o  output  1  block can accept a request.
REQ-007 SHALL have port alu_op_i  input  5  operation code (REQ-012).
REQ-008 SHALL have port rs1_data_i / rs2_data_i  input  XLEN each  operands.
REQ-009 SHALL have port flush_i  input  1  abort in-flight operation.
REQ-010 SHALL have port out_valid_o  output  1  result valid; out_ready_i  input  1  consumer accepts.
REQ-011 SHALL have port rd_data_o  output  XLEN  registered result.

Function
REQ-012 SHALL decode alu_op_i: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; codes 18-31 produce 0 with basic-op latency.
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; IDLE->DONE on accept of basic op (0-9, 18-31), IDLE->BUSY on accept of op 10-17, BUSY->DONE when iteration counter reaches XLEN, DONE->IDLE when out_ready_i=1.
REQ-014 SHALL drive in_ready_o = (state==IDLE) && !rst_i && !flush_i; accept occurs on a rising edge with in_valid_i && in_ready_o; operands and op are captured at accept and later input changes are ignored.
REQ-015 SHALL assert out_valid_o only in DONE, holding rd_data_o stable until out_ready_i=1.
REQ-016 Latency SHALL be exactly 1 cycle for basic ops and XLEN+1 cycles for ops 10-17 (accept edge to first cycle with out_valid_o=1), independent of operand values.
REQ-017 Basic ops: ADD/SUB/logic modulo 2^XLEN; SLT signed, SLTU unsigned, result zero-extended to XLEN; SRA arithmetic, SRL/SLL logical, shift amount rs2[SHW-1:0].
REQ-018 MUL SHALL return low XLEN bits of product; MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned, returning high XLEN bits; implemented as iterative shift-add, one bit per cycle.
REQ-019 DIV/DIVU/REM/REMU SHALL use iterative restoring division, one quotient bit per cycle; signed results truncate toward zero, remainder takes sign of dividend.
REQ-020 Divide by zero SHALL return quotient all ones, remainder = rs1; signed overflow (rs1 = most-negative, rs2 = -1) SHALL return quotient = rs1, remainder 0; latency unchanged.
REQ-021 flush_i=1 on an edge SHALL force state IDLE, clear out_valid_o and the iteration counter, and discard any result; flush wins over a simultaneous accept or out_ready_i.
REQ-022 Result SHALL be delivered exactly once; no new request is accepted while BUSY or DONE.
REQ-023 Back-to-back throughput SHALL be one basic op every 2 cycles when out_ready_i is held 1.

Reset
REQ-024 rst_i=1 on an edge SHALL set state IDLE, out_valid_o=0, rd_data_o=0, counter=0, regardless of state, including mid-BUSY.
REQ-025 While rst_i=1, in_ready_o SHALL be 0; it SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-026 ADD 0x7FFFFFFF + 0x00000001, out_ready_i=1 -> out_valid_o next cycle, rd_data_o=0x80000000, in_ready_o=1 following cycle.
REQ-027 SRA 0x80000000 by rs2=0x24 -> shift 4 -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
REQ-028 MULH 0x80000000 x 0x80000000 -> 0x40000000 after exactly 33 cycles; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-029 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -7 / 2 -> 0xFFFFFFFF; DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
REQ-030 out_ready_i=0 for 5 cycles in DONE -> rd_data_o and out_valid_o stable, in_ready_o=0, new in_valid_i ignored.
REQ-031 flush_i and rst_i asserted at cycle 10 of a DIV -> next cycle IDLE, out_valid_o=0, no stale result ever emitted; fresh ADD 2+3 then returns 5.
